// File: rtl/qenc_decoder.sv
// Quadrature encoder front end: synchronizes and de-glitches A/B and tracks a wrapping signed position.
// Latency is SYNC_STAGES + FILT_LEN + 1 clk from pin change to cnt/step; there is no backpressure.
module qenc_decoder #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a,
  input  logic                    b,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    err_clr,
  output logic signed [CNT_W-1:0] cnt,
  output logic                    step,
  output logic                    dir,
  output logic                    err
);

  localparam int RUN_W = $clog2(FILT_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(FILT_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             samp;

  logic [1:0]       cand;
  logic [1:0]       filt;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic             hit;
  logic             accept;
  logic             upd;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ref_ab;
  logic [1:0]       ref_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             step_nxt;
  logic             dir_nxt;
  logic             err_nxt;
  logic             is_cw;
  logic             is_ccw;
  logic             is_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b};
    end
  end

  assign samp = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // Run length of the current synchronized value; saturates so a held value is accepted only once.
  always_comb begin
    run_nxt = RUN_ONE;
    if (samp == cand) begin
      run_nxt = (run == RUN_FULL) ? run : run + RUN_ONE;
    end
  end

  assign hit    = (run_nxt == RUN_FULL) && !((samp == cand) && (run == RUN_FULL));
  assign accept = hit && ((samp != filt) || (state == INIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand <= 2'b00;
      run  <= '0;
      filt <= 2'b00;
      upd  <= 1'b0;
    end else begin
      cand <= samp;
      run  <= run_nxt;
      upd  <= accept;
      if (accept) begin
        filt <= samp;
      end
    end
  end

  // cw order is 00 -> 10 -> 11 -> 01 -> 00 on {a,b}.
  always_comb begin
    is_cw  = 1'b0;
    is_ccw = 1'b0;
    case (ref_ab)
      2'b00: begin is_cw = (filt == 2'b10); is_ccw = (filt == 2'b01); end
      2'b10: begin is_cw = (filt == 2'b11); is_ccw = (filt == 2'b00); end
      2'b11: begin is_cw = (filt == 2'b01); is_ccw = (filt == 2'b10); end
      default: begin is_cw = (filt == 2'b00); is_ccw = (filt == 2'b11); end
    endcase
    is_bad = ((ref_ab ^ filt) == 2'b11);
  end

  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_ab;
    cnt_nxt   = cnt;
    step_nxt  = 1'b0;
    dir_nxt   = dir;
    err_nxt   = err & ~err_clr;
    if (upd) begin
      ref_nxt = filt;
      case (state)
        INIT: begin
          state_nxt = TRACK;
        end
        default: begin
          if (en) begin
            if (is_cw) begin
              cnt_nxt  = cnt + CNT_ONE;
              dir_nxt  = 1'b0;
              step_nxt = 1'b1;
            end else if (is_ccw) begin
              cnt_nxt  = cnt - CNT_ONE;
              dir_nxt  = 1'b1;
              step_nxt = 1'b1;
            end else if (is_bad) begin
              err_nxt = 1'b1;
            end
          end
        end
      endcase
    end
    if (clr) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= INIT;
      ref_ab <= 2'b00;
      cnt    <= '0;
      step   <= 1'b0;
      dir    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ref_ab <= ref_nxt;
      cnt    <= cnt_nxt;
      step   <= step_nxt;
      dir    <= dir_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_qenc_decoder.sv
// Bench for qenc_decoder: steps are predicted into a scoreboard when pins are driven and matched on step pulses.
module tb_qenc_decoder;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int LAT   = SYNC + FILT + 1;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] cnt;
    logic             dir;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    a;
  logic                    b;
  logic                    en;
  logic                    clr;
  logic                    err_clr;
  logic signed [CNT_W-1:0] cnt;
  logic                    step;
  logic                    dir;
  logic                    err;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  exp_t             sb[$];
  logic [1:0]       cw_seq [0:3];
  logic [1:0]       model_ab;
  logic [CNT_W-1:0] model_cnt;
  logic             model_dir;
  logic             model_err;

  qenc_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .clr(clr), .err_clr(err_clr),
    .cnt(cnt), .step(step), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cnt=%h required=finished", cnt);
    $fatal(1, "watchdog expired");
  end

  // Called right after a negedge. Optionally pulses clr / err_clr on the edge that processes the change.
  task automatic drive_ab(input logic [1:0] nab, input bit pulse_clr, input bit pulse_errclr);
    int   ip;
    int   inn;
    bit   bad;
    exp_t e;
    ip  = 0;
    inn = 0;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (cw_seq[k] == model_ab) ip = k;
      if (cw_seq[k] == nab) inn = k;
    end
    a = nab[1];
    b = nab[0];
    if (nab != model_ab && en) begin
      if (inn == (ip + 1) % 4) begin
        model_cnt = model_cnt + 1'b1;
        model_dir = 1'b0;
      end else if (ip == (inn + 1) % 4) begin
        model_cnt = model_cnt - 1'b1;
        model_dir = 1'b1;
      end else begin
        bad = 1'b1;
      end
      if (pulse_clr) model_cnt = '0;
      if (!bad) begin
        e.cyc = cyc + LAT;
        e.cnt = model_cnt;
        e.dir = model_dir;
        sb.push_back(e);
      end
    end
    if (pulse_errclr) model_err = 1'b0;
    if (bad) model_err = 1'b1;
    model_ab = nab;
    repeat (LAT - 1) @(negedge clk);
    clr     = pulse_clr;
    err_clr = pulse_errclr;
    @(negedge clk);
    clr     = 1'b0;
    err_clr = 1'b0;
    repeat (20 - LAT) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = 1'b0; b = 1'b0; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cnt !== 16'sd0) begin errors++; $display("FAIL reset_cnt got=%h want=0", cnt); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got=%b want=0", step); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b want=0", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    rst_n = 1'b1;
    model_ab = 2'b00; model_cnt = '0; model_dir = 1'b0; model_err = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (cnt !== 16'sd0 || err !== 1'b0) begin errors++; $display("FAIL init_baseline cnt=%h err=%b want 0/0", cnt, err); end
  endtask

  task automatic test_cw_cycle();
    drive_ab(2'b10, 0, 0);
    drive_ab(2'b11, 0, 0);
    drive_ab(2'b01, 0, 0);
    drive_ab(2'b00, 0, 0);
    checks++; if (cnt !== 16'sd4) begin errors++; $display("FAIL cw_cnt got=%h want=0004", cnt); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL cw_dir got=%b want=0", dir); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL cw_missing_steps got=%0d want=0", sb.size()); end
  endtask

  task automatic test_ccw_cycles();
    for (int r = 0; r < 2; r++) begin
      drive_ab(2'b01, 0, 0);
      drive_ab(2'b11, 0, 0);
      drive_ab(2'b10, 0, 0);
      drive_ab(2'b00, 0, 0);
    end
    checks++; if (cnt !== 16'shFFFC) begin errors++; $display("FAIL ccw_cnt got=%h want=fffc", cnt); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL ccw_dir got=%b want=1", dir); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ccw_err got=%b want=0", err); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ccw_missing_steps got=%0d want=0", sb.size()); end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 30; r++) begin
      a = 1'b1;
      repeat (FILT - 1) @(negedge clk);
      a = 1'b0;
      repeat ($urandom_range(6, 2)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++; if (cnt !== model_cnt) begin errors++; $display("FAIL glitch_cnt got=%h want=%h", cnt, model_cnt); end
    drive_ab(2'b10, 0, 0);
    checks++; if (cnt !== 16'shFFFD) begin errors++; $display("FAIL glitch_hold_cnt got=%h want=fffd", cnt); end
    drive_ab(2'b00, 0, 0);
    checks++; if (cnt !== 16'shFFFC) begin errors++; $display("FAIL glitch_back_cnt got=%h want=fffc", cnt); end
  endtask

  task automatic test_illegal();
    drive_ab(2'b11, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%b want=1", err); end
    checks++; if (cnt !== 16'shFFFC) begin errors++; $display("FAIL illegal_cnt got=%h want=fffc", cnt); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b want=0", err); end
    drive_ab(2'b00, 0, 1);
    checks++; if (err !== model_err) begin errors++; $display("FAIL err_vs_clr got=%b want=%b", err, model_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 1'b0;
    checks++; if (err !== 1'b0 || cnt !== model_cnt) begin errors++; $display("FAIL illegal_end err=%b cnt=%h want 0/%h", err, cnt, model_cnt); end
  endtask

  task automatic test_wrap_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_cnt = '0;
    checks++; if (cnt !== 16'sd0) begin errors++; $display("FAIL clr_cnt got=%h want=0000", cnt); end
    drive_ab(2'b01, 0, 0);
    checks++; if (cnt !== 16'shFFFF) begin errors++; $display("FAIL wrap_down got=%h want=ffff", cnt); end
    drive_ab(2'b00, 0, 0);
    checks++; if (cnt !== 16'sd0) begin errors++; $display("FAIL wrap_up got=%h want=0000", cnt); end
    drive_ab(2'b10, 0, 0);
    drive_ab(2'b11, 1, 0);
    checks++; if (cnt !== 16'sd0 || dir !== 1'b0) begin errors++; $display("FAIL clr_with_step cnt=%h dir=%b want 0000/0", cnt, dir); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_missing_steps got=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset_enable();
    // Pins stay at 11 through reset; the decoder must adopt them silently.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_cnt = '0; model_dir = 1'b0; model_err = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (cnt !== 16'sd0 || err !== 1'b0) begin errors++; $display("FAIL rst_mid cnt=%h err=%b want 0000/0", cnt, err); end
    drive_ab(2'b01, 0, 0);
    checks++; if (cnt !== 16'sd1 || dir !== 1'b0) begin errors++; $display("FAIL rst_then_cw cnt=%h dir=%b want 0001/0", cnt, dir); end
    en = 1'b0;
    drive_ab(2'b00, 0, 0);
    drive_ab(2'b10, 0, 0);
    drive_ab(2'b11, 0, 0);
    drive_ab(2'b01, 0, 0);
    checks++; if (cnt !== 16'sd1) begin errors++; $display("FAIL en_off_cnt got=%h want=0001", cnt); end
    en = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (cnt !== 16'sd1 || sb.size() != 0) begin errors++; $display("FAIL en_catchup cnt=%h q=%0d want 0001/0", cnt, sb.size()); end
    drive_ab(2'b00, 0, 0);
    checks++; if (cnt !== 16'sd2) begin errors++; $display("FAIL en_back_on got=%h want=0002", cnt); end
  endtask

  initial begin
    exp_t m;
    cw_seq[0] = 2'b00; cw_seq[1] = 2'b10; cw_seq[2] = 2'b11; cw_seq[3] = 2'b01;
    rst_n = 1'b0; a = 1'b0; b = 1'b0; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    fork
      forever begin
        @(negedge clk);
        if (rst_n && step === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step cnt=%h dir=%b cyc=%0d want=no step", cnt, dir, cyc);
          end else begin
            m = sb.pop_front();
            if (cnt !== m.cnt || dir !== m.dir || cyc != m.cyc) begin
              errors++;
              $display("FAIL step_match cnt=%h dir=%b cyc=%0d want cnt=%h dir=%b cyc=%0d",
                       cnt, dir, cyc, m.cnt, m.dir, m.cyc);
            end
          end
        end
      end
    join_none
    test_reset();
    test_cw_cycle();
    test_ccw_cycles();
    test_glitch();
    test_illegal();
    test_wrap_clr();
    test_reset_enable();
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
